// File: rtl/izigzag_pkg.sv
// Shared types and the JPEG zigzag-to-raster map for the inverse-zigzag distributor.
// Pure constants and types, no timing or flow control of its own.
package izigzag_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    PAD = 2'd1,
    EOS = 2'd2
  } wr_state_t;

  // Entry k is the raster position of the k-th coefficient in zigzag scan.
  localparam logic [5:0] ZZ_TO_RASTER [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [5:0] wr_addr(input logic zz, input logic [5:0] idx);
    return zz ? ZZ_TO_RASTER[idx] : idx;
  endfunction

endpackage

// File: rtl/izigzag_bank.sv
// Two 64-entry coefficient banks: one synchronous write port, CH combinational read ports.
// Reads are zero-latency; no flow control here, the top gates every access.
module izigzag_bank #(
  parameter int W  = 16,
  parameter int CH = 8
) (
  input  logic            clock,
  input  logic            we,
  input  logic            wbank,
  input  logic [5:0]      waddr,
  input  logic [W-1:0]    wdata,
  input  logic            rbank,
  input  logic [CH*6-1:0] raddr,
  output logic [CH*W-1:0] rdata
);

  logic [W-1:0] mem [2][64];

  always_ff @(posedge clock) begin
    if (we) mem[wbank][waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < CH; c++) begin
      rdata[c*W +: W] = mem[rbank][raddr[c*6 +: 6]];
    end
  end

endmodule

// File: rtl/izigzag_stream_deal.sv
// Inverse-zigzag dealer: one zigzag/raster stream in, CH raster streams out via ping-pong banks.
// Output valid one cycle after a block's 64th accept; ruS_b holds while the write bank is FULL or in PAD/EOS.
module izigzag_stream_deal
  import izigzag_pkg::*;
#(
  parameter int W       = 16,
  parameter int CH      = 8,
  parameter int MODE_ZZ = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [W-1:0]    ruS_d,
  input  logic            ruS_e,
  input  logic            ruS_v,
  output logic            ruS_b,
  output logic [CH*W-1:0] chu_d,
  output logic [CH-1:0]   chu_e,
  output logic [CH-1:0]   chu_v,
  input  logic [CH-1:0]   chu_b
);

  localparam int JN = 64 / CH;
  localparam int JW = $clog2(JN);

  generate
    if (CH != 1 && CH != 2 && CH != 4 && CH != 8) begin : g_bad_ch
      $error("izigzag_stream_deal: CH must be 1, 2, 4 or 8");
    end
  endgenerate

  bank_state_t bank_st [2];
  wr_state_t   wst;
  logic        wb;
  logic        rb;
  logic [5:0]  wcnt;
  logic [JW-1:0] jc [CH];
  logic [CH-1:0] done;
  logic [CH-1:0] eos_tok;
  logic          eos_out;

  logic            accept;
  logic            wr_pad;
  logic            we;
  logic            last;
  logic [5:0]      waddr;
  logic [W-1:0]    wdata;
  logic            rd_act;
  logic            drain_done;
  logic [CH-1:0]   data_v;
  logic [CH-1:0]   j_last;
  logic [CH-1:0]   fin;
  logic [CH*6-1:0] raddr;
  logic [CH*W-1:0] rdata;

  // Write side
  always_comb begin
    ruS_b  = reset || (bank_st[wb] == FULL) || (wst != RUN);
    accept = ruS_v && !ruS_b;
    wr_pad = (wst == PAD);
    we     = (accept && !ruS_e) || wr_pad;
    last   = (wcnt == 6'd63);
    waddr  = wr_addr(MODE_ZZ != 0, wcnt);
    wdata  = wr_pad ? '0 : ruS_d;
  end

  // Read side: channel c walks raster indices c, c+CH, c+2*CH, ...
  always_comb begin
    rd_act = (bank_st[rb] == FULL);
    data_v = '0;
    j_last = '0;
    fin    = '0;
    raddr  = '0;
    for (int c = 0; c < CH; c++) begin
      data_v[c] = rd_act && !done[c];
      j_last[c] = (jc[c] == JW'(JN - 1));
      fin[c]    = done[c] || (data_v[c] && !chu_b[c] && j_last[c]);
      raddr[c*6 +: 6] = 6'((int'(jc[c]) * CH) + c);
    end
    drain_done = rd_act && (&fin);
  end

  izigzag_bank #(.W(W), .CH(CH)) u_bank (
    .clock (clock),
    .we    (we),
    .wbank (wb),
    .waddr (waddr),
    .wdata (wdata),
    .rbank (rb),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    chu_v = data_v | eos_tok;
    chu_e = eos_tok;
    chu_d = '0;
    for (int c = 0; c < CH; c++) begin
      if (data_v[c]) chu_d[c*W +: W] = rdata[c*W +: W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wst        <= RUN;
      wb         <= 1'b0;
      rb         <= 1'b0;
      wcnt       <= '0;
      done       <= '0;
      eos_tok    <= '0;
      eos_out    <= 1'b0;
      for (int c = 0; c < CH; c++) jc[c] <= '0;
    end else begin
      // rb is FULL and wb is not FULL when both update, so they never hit the same bank.
      if (drain_done) begin
        bank_st[rb] <= EMPTY;
        rb          <= ~rb;
        done        <= '0;
        for (int c = 0; c < CH; c++) jc[c] <= '0;
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (data_v[c] && !chu_b[c]) begin
            if (j_last[c]) done[c] <= 1'b1;
            else           jc[c]   <= jc[c] + 1'b1;
          end
        end
      end

      if (we) begin
        if (last) begin
          bank_st[wb] <= FULL;
          wb          <= ~wb;
          wcnt        <= '0;
          if (wr_pad) wst <= EOS;
        end else begin
          bank_st[wb] <= FILLING;
          wcnt        <= wcnt + 6'd1;
        end
      end

      if (wst == RUN && accept && ruS_e) begin
        wst <= (wcnt != 6'd0) ? PAD : EOS;
      end

      if (wst == EOS) begin
        if (!eos_out) begin
          if (bank_st[0] == EMPTY && bank_st[1] == EMPTY) begin
            eos_out <= 1'b1;
            eos_tok <= '1;
          end
        end else begin
          eos_tok <= eos_tok & chu_b;
          if ((eos_tok & chu_b) == '0) begin
            eos_out <= 1'b0;
            wst     <= RUN;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_izigzag_stream_deal.sv
// Scoreboard bench: three configurations (CH=8 zigzag, CH=8 raster, CH=1 raster) driven with directed blocks.
module tb_izigzag_stream_deal;

  typedef logic [16:0] tok_t;  // {e, d}

  // Standard JPEG zigzag index at each raster position (row-major).
  localparam int RZ [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] in_d [3];
  logic        in_e [3];
  logic        in_v [3];
  logic b_z, b_r, b_p;

  logic [127:0] zo_d;
  logic [7:0]   zo_e, zo_v, zo_b;
  logic [127:0] ro_d;
  logic [7:0]   ro_e, ro_v, ro_b;
  logic [15:0]  po_d;
  logic [0:0]   po_e, po_v, po_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_seen = 0;

  tok_t qz [8][$];
  tok_t qr [8][$];
  tok_t qp [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  izigzag_stream_deal #(.W(16), .CH(8), .MODE_ZZ(1)) u_z (
    .clock(clock), .reset(reset),
    .ruS_d(in_d[0]), .ruS_e(in_e[0]), .ruS_v(in_v[0]), .ruS_b(b_z),
    .chu_d(zo_d), .chu_e(zo_e), .chu_v(zo_v), .chu_b(zo_b));

  izigzag_stream_deal #(.W(16), .CH(8), .MODE_ZZ(0)) u_r (
    .clock(clock), .reset(reset),
    .ruS_d(in_d[1]), .ruS_e(in_e[1]), .ruS_v(in_v[1]), .ruS_b(b_r),
    .chu_d(ro_d), .chu_e(ro_e), .chu_v(ro_v), .chu_b(ro_b));

  izigzag_stream_deal #(.W(16), .CH(1), .MODE_ZZ(0)) u_p (
    .clock(clock), .reset(reset),
    .ruS_d(in_d[2]), .ruS_e(in_e[2]), .ruS_v(in_v[2]), .ruS_b(b_p),
    .chu_d(po_d), .chu_e(po_e), .chu_v(po_v), .chu_b(po_b));

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not met", name);
  endtask

  function automatic int qtotal();
    int s = qp.size();
    for (int c = 0; c < 8; c++) s += qz[c].size() + qr[c].size();
    return s;
  endfunction

  function automatic logic get_b(input int k);
    case (k)
      0:       return b_z;
      1:       return b_r;
      default: return b_p;
    endcase
  endfunction

  // Monitor: called at negedge, a token fires at the next posedge when v=1, b=0.
  task automatic mon_step();
    tok_t t;
    for (int c = 0; c < 8; c++) begin
      if (zo_v[c] && !zo_b[c]) begin
        if (qz[c].size() == 0) fail_now($sformatf("z_extra_ch%0d", c));
        else begin
          t = qz[c].pop_front();
          cmp($sformatf("z_tok_ch%0d", c), {15'd0, zo_e[c], zo_d[c*16 +: 16]}, {15'd0, t});
        end
      end
      if (ro_v[c] && !ro_b[c]) begin
        if (qr[c].size() == 0) fail_now($sformatf("r_extra_ch%0d", c));
        else begin
          t = qr[c].pop_front();
          cmp($sformatf("r_tok_ch%0d", c), {15'd0, ro_e[c], ro_d[c*16 +: 16]}, {15'd0, t});
        end
      end
    end
    if (po_v[0] && !po_b[0]) begin
      if (qp.size() == 0) fail_now("p_extra");
      else begin
        t = qp.pop_front();
        cmp("p_tok", {15'd0, po_e[0], po_d}, {15'd0, t});
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the token was accepted.
  task automatic put(input int k, input logic e, input logic [15:0] d);
    int budget = 0;
    in_d[k] = d;
    in_e[k] = e;
    in_v[k] = 1'b1;
    @(negedge clock);
    while (get_b(k) && budget < 300) begin
      budget++;
      @(negedge clock);
    end
    if (budget > 0) stall_seen++;
    if (budget >= 300) fail_now("put_timeout");
    tick();
    in_v[k] = 1'b0;
    in_e[k] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int budget = 0;
    while (qtotal() != 0 && budget < 400) begin
      budget++;
      tick();
    end
    cmp(name, qtotal(), 0);
  endtask

  task automatic run_tests();
    int cnt;
    int c0;
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    cmp("rst_b", {b_z, b_r, b_p}, 3'b111);
    cmp("rst_v", {zo_v, ro_v, po_v}, 0);
    cmp("rst_e", {zo_e, ro_e, po_e}, 0);
    cmp("rst_d", (zo_d != 0) || (ro_d != 0) || (po_d != 0), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    cmp("rst_b_release", {b_z, b_r, b_p}, 0);
    tick();

    // Zigzag remap, CH=8
    for (int r = 0; r < 64; r++) qz[r % 8].push_back({1'b0, 16'(RZ[r])});
    for (int i = 0; i < 63; i++) put(0, 1'b0, 16'(i));
    cmp("zz_v_early", zo_v, 0);
    put(0, 1'b0, 16'd63);
    cmp("zz_v_rise", zo_v, 8'hFF);
    wait_drain("zz_drain");

    // Pass-through, CH=1
    for (int i = 0; i < 64; i++) qp.push_back({1'b0, 16'(100 + i)});
    for (int i = 0; i < 64; i++) put(2, 1'b0, 16'(100 + i));
    cnt = 0;
    while (po_v[0] && cnt < 200) begin
      cnt++;
      tick();
    end
    cmp("pt_cycles", cnt, 64);
    wait_drain("pt_drain");

    // Independent stall on channel 3
    zo_b = 8'h08;
    for (int r = 0; r < 64; r++) qz[r % 8].push_back({1'b0, 16'(200 + RZ[r])});
    for (int i = 0; i < 64; i++) put(0, 1'b0, 16'(200 + i));
    repeat (8) tick();
    cmp("stall_others_done", zo_v, 8'h08);
    cmp("stall_b_free", b_z, 0);
    for (int r = 0; r < 64; r++) qz[r % 8].push_back({1'b0, 16'(400 + RZ[r])});
    for (int i = 0; i < 64; i++) put(0, 1'b0, 16'(400 + i));
    cmp("both_full_b", b_z, 1);
    cmp("ch3_held", zo_v, 8'h08);
    zo_b = 8'h00;
    repeat (7) tick();
    cmp("bank_held", b_z, 1);
    tick();
    cmp("bank_freed", b_z, 0);
    wait_drain("stall_drain");

    // Back-to-back blocks
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < 64; r++) qz[r % 8].push_back({1'b0, 16'(1000 * (b + 1) + RZ[r])});
    stall_seen = 0;
    c0 = cyc;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 64; i++) put(0, 1'b0, 16'(1000 * (b + 1) + i));
    cmp("b2b_cycles", cyc - c0, 192);
    cmp("b2b_no_bp", stall_seen, 0);
    wait_drain("b2b_drain");

    // Truncated block, raster mode CH=8
    for (int r = 0; r < 64; r++) qr[r % 8].push_back({1'b0, (r < 10) ? 16'(r + 1) : 16'd0});
    for (int c = 0; c < 8; c++) qr[c].push_back({1'b1, 16'd0});
    for (int i = 1; i <= 10; i++) put(1, 1'b0, 16'(i));
    put(1, 1'b1, 16'd0);
    cmp("eos_b_rise", b_r, 1);
    cnt = 0;
    while (b_r && cnt < 400) begin
      cnt++;
      tick();
    end
    cmp("eos_b_release", b_r, 0);
    cmp("eos_tokens_done", qtotal(), 0);
    cmp("eos_idle_v", {ro_v, ro_e}, 0);

    // Reset mid-drain
    for (int r = 0; r < 32; r++) qz[r % 8].push_back({1'b0, 16'(500 + RZ[r])});
    for (int i = 0; i < 64; i++) put(0, 1'b0, 16'(500 + i));
    repeat (4) tick();
    zo_b = 8'hFF;
    reset = 1'b1;
    tick();
    cmp("mid_rst_b", b_z, 1);
    reset = 1'b0;
    @(negedge clock);
    cmp("mid_v", zo_v, 0);
    cmp("mid_b", b_z, 0);
    cmp("mid_q", qtotal(), 0);
    tick();
    zo_b = 8'h00;
    for (int r = 0; r < 64; r++) qz[r % 8].push_back({1'b0, 16'(700 + RZ[r])});
    for (int i = 0; i < 64; i++) put(0, 1'b0, 16'(700 + i));
    wait_drain("fresh_drain");
    repeat (4) tick();
    cmp("final_idle_v", {zo_v, ro_v, po_v}, 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_d[k] = '0;
      in_e[k] = 1'b0;
      in_v[k] = 1'b0;
    end
    zo_b = '0;
    ro_b = '0;
    po_b = '0;
    fork
      forever begin
        @(negedge clock);
        if (!reset) mon_step();
      end
      run_tests();
      begin
        #500000;
        fail_now("global_timeout");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
